clk_div_multi: RTL and testbench

Multi-channel programmable clock divider: the parametrised successor of the fixed single-divisor divider. It produces NUM_CH independent divided outputs from the 10 MHz system clock. Each channel has a runtime-writable divisor, a near-50 % square wave and a one-cycle tick strobe. The block drives the sensor sampling, display scan and buzzer timing domains from one instance.

---
 rtl/clk_div_pkg.sv | 21 ++
 rtl/div_chan.sv | 101 ++++++++++
 rtl/clk_div_multi.sv | 63 ++++++
 tb/tb_clk_div_multi.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants, helpers and types for the multi-channel clock divider.
//   CNT_W    : default divisor/counter width
//   DEF_DIV  : divisor every channel holds after reset (10 MHz / 100 = 100 kHz)
//   ch_width : width of a channel index, never less than one bit
//   chan_cfg_t : per-channel divisor state {div, pend_div, pend}
package clk_div_pkg;

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned DEF_DIV = 100;

    function automatic int unsigned ch_width(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    typedef struct packed {
        logic [CNT_W-1:0] div;
        logic [CNT_W-1:0] pend_div;
        logic             pend;
    } chan_cfg_t;

endpackage

// File: rtl/div_chan.sv
// One divider channel: period counter, pending-divisor register and
// registered tick/wave generation.
//   clk_in  : system clock
//   rst     : synchronous active-high reset
//   en      : run enable for this channel
//   restart : phase-align pulse shared by all channels
//   wr      : accepted divisor write for this channel
//   wr_div  : divisor carried by the write
//   pend    : a divisor is waiting for the period boundary
//   tick    : one-cycle strobe per period
//   wave    : divided square wave, floor(D/2) high / ceil(D/2) low
module div_chan #(
    parameter int unsigned CNT_W   = clk_div_pkg::CNT_W,
    parameter int unsigned DEF_DIV = clk_div_pkg::DEF_DIV
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             pend,
    output logic             tick,
    output logic             wave
);
    import clk_div_pkg::*;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             wave_q, wave_d;
    logic             stopped;
    logic             boundary;

    assign stopped  = restart || !en || (div_q == '0);
    // Only meaningful while running, where div_q >= 1 so the subtraction cannot wrap.
    assign boundary = (cnt_q == (div_q - CNT_W'(1)));

    always_comb begin
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_div_d = pend_div_q;
        pend_d     = pend_q;
        tick_d     = 1'b0;
        wave_d     = 1'b0;

        if (stopped) begin
            // Nothing is mid-period, so writes and pending values land at once.
            cnt_d  = '0;
            pend_d = 1'b0;
            if (wr) begin
                div_d = wr_div;
            end else if (pend_q) begin
                div_d = pend_div_q;
            end
        end else begin
            if (boundary) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (pend_q) begin
                    div_d  = pend_div_q;
                    pend_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            // wr implies pend_q was clear, so it never collides with the apply above.
            if (wr) begin
                pend_div_d = wr_div;
                pend_d     = 1'b1;
            end
            // Compare against the divisor of the period cnt_d belongs to.
            wave_d = (cnt_d < (div_d >> 1));
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q      <= '0;
            div_q      <= CNT_W'(DEF_DIV);
            pend_div_q <= '0;
            pend_q     <= 1'b0;
            tick_q     <= 1'b0;
            wave_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            wave_q     <= wave_d;
        end
    end

    assign pend = pend_q;
    assign tick = tick_q;
    assign wave = wave_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider. Decodes divisor writes to the
// target channel, muxes cfg_ready and fans restart out to all channels.
//   clk_in    : 10 MHz system clock
//   rst       : synchronous active-high reset
//   en        : per-channel run enable
//   restart   : one-cycle pulse, phase-aligns all channels
//   cfg_valid : divisor write request
//   cfg_ready : write can be accepted (combinational from cfg_ch and pend)
//   cfg_ch    : target channel; out-of-range indices are accepted and dropped
//   cfg_div   : new divisor
//   tick      : per-channel one-cycle strobe
//   wave      : per-channel divided square wave
module clk_div_multi #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = clk_div_pkg::CNT_W,
    parameter int unsigned DEF_DIV = clk_div_pkg::DEF_DIV,
    localparam int unsigned CH_W   = clk_div_pkg::ch_width(NUM_CH)
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              restart,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] wave
);
    import clk_div_pkg::*;

    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] wr;

    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pend[i];
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

        div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk_in  (clk_in),
            .rst     (rst),
            .en      (en[i]),
            .restart (restart),
            .wr      (wr[i]),
            .wr_div  (cfg_div),
            .pend    (pend[i]),
            .tick    (tick[i]),
            .wave    (wave[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with a cycle model feeding a scoreboard.
module tb_clk_div_multi;

    localparam int NCH = 5;

    logic            clk_in = 1'b0;
    logic            rst = 1'b1;
    logic [NCH-1:0]  en = '0;
    logic            restart = 1'b0;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [2:0]      cfg_ch = '0;
    logic [31:0]     cfg_div = '0;
    logic [NCH-1:0]  tick;
    logic [NCH-1:0]  wave;

    clk_div_multi #(
        .NUM_CH  (NCH),
        .CNT_W   (32),
        .DEF_DIV (100)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
        .restart   (restart),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .tick      (tick),
        .wave      (wave)
    );

    always #50 clk_in = ~clk_in;

    int n_vec = 0;
    int n_miss = 0;

    // Reference model state
    logic [31:0]    m_cnt  [NCH];
    logic [31:0]    m_div  [NCH];
    logic [31:0]    m_pdiv [NCH];
    logic           m_pend [NCH];
    logic [NCH-1:0] m_tick;
    logic [NCH-1:0] m_wave;

    typedef struct packed {
        logic [NCH-1:0] t;
        logic [NCH-1:0] w;
    } exp_t;
    exp_t exp_q[$];

    // Observation trackers
    int cyc = 0;
    int last_tick [NCH];
    int period    [NCH];
    int tick_cnt  [NCH];
    int hi_cnt    [NCH];
    int run_len   [NCH];
    logic run_val [NCH];
    int hi_len    [NCH];
    int lo_len    [NCH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_ready();
        if (int'(cfg_ch) >= NCH) return 1'b1;
        return !m_pend[cfg_ch];
    endfunction

    task automatic model_next();
        logic acc;
        logic last;
        for (int c = 0; c < NCH; c++) begin
            acc = cfg_valid && (int'(cfg_ch) == c) && !m_pend[c];
            if (rst) begin
                m_cnt[c] = 0; m_div[c] = 100; m_pend[c] = 0; m_pdiv[c] = 0;
                m_tick[c] = 0; m_wave[c] = 0;
            end else if (restart || !en[c] || m_div[c] == 0) begin
                if (acc) m_div[c] = cfg_div;
                else if (m_pend[c]) m_div[c] = m_pdiv[c];
                m_pend[c] = 0; m_cnt[c] = 0; m_tick[c] = 0; m_wave[c] = 0;
            end else begin
                last = (m_cnt[c] == m_div[c] - 1);
                m_tick[c] = last;
                if (last) begin
                    m_cnt[c] = 0;
                    if (m_pend[c]) begin
                        m_div[c] = m_pdiv[c];
                        m_pend[c] = 0;
                    end
                end else begin
                    m_cnt[c] = m_cnt[c] + 1;
                end
                if (acc) begin
                    m_pdiv[c] = cfg_div;
                    m_pend[c] = 1;
                end
                m_wave[c] = (m_cnt[c] < m_div[c] / 2);
            end
        end
    endtask

    task automatic track();
        cyc++;
        for (int c = 0; c < NCH; c++) begin
            if (tick[c]) begin
                period[c] = cyc - last_tick[c];
                last_tick[c] = cyc;
                tick_cnt[c]++;
            end
            if (wave[c]) hi_cnt[c]++;
            if (wave[c] !== run_val[c]) begin
                if (run_val[c]) hi_len[c] = run_len[c];
                else lo_len[c] = run_len[c];
                run_val[c] = wave[c];
                run_len[c] = 1;
            end else begin
                run_len[c]++;
            end
        end
    endtask

    task automatic clr_counts();
        for (int c = 0; c < NCH; c++) begin
            tick_cnt[c] = 0;
            hi_cnt[c] = 0;
        end
    endtask

    // Inputs are set at the negedge; outputs sampled on the following negedge.
    task automatic step();
        exp_t e;
        #1;
        if (!rst) chk("cfg_ready", 32'(cfg_ready), 32'(model_ready()));
        model_next();
        e.t = m_tick;
        e.w = m_wave;
        exp_q.push_back(e);
        @(posedge clk_in);
        @(negedge clk_in);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL scoreboard: observed empty queue expected one entry");
        end else begin
            e = exp_q.pop_front();
            chk("tick", 32'(tick), 32'(e.t));
            chk("wave", 32'(wave), 32'(e.w));
        end
        track();
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_div[c] = 100; m_pdiv[c] = 0; m_pend[c] = 0;
            last_tick[c] = 0; period[c] = 0; tick_cnt[c] = 0; hi_cnt[c] = 0;
            run_len[c] = 0; run_val[c] = 1'b0; hi_len[c] = 0; lo_len[c] = 0;
        end
        m_tick = '0;
        m_wave = '0;

        // Reset
        @(negedge clk_in);
        rst = 1'b1;
        step();
        step();
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_wave", 32'(wave), 32'd0);
        #1 chk("rst_ready", 32'(cfg_ready), 32'd1);

        // Defaults: 100-cycle period, first tick after edge 100
        rst = 1'b0;
        en = '1;
        cyc = 0;
        for (int c = 0; c < NCH; c++) last_tick[c] = 0;
        repeat (99) step();
        chk("first_tick_early", 32'(tick[0]), 32'd0);
        step();
        chk("first_tick", 32'(tick), 32'h1F);
        repeat (105) step();
        chk("def_period", 32'(period[0]), 32'd100);
        chk("def_hi", 32'(hi_len[0]), 32'd50);
        chk("def_lo", 32'(lo_len[0]), 32'd50);

        // D=7 to ch1 mid-period
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 32'd7;
        step();
        cfg_valid = 1'b0;
        #1 chk("ch1_ready_pend", 32'(cfg_ready), 32'd0);
        while (cyc < 330) step();
        chk("ch1_period", 32'(period[1]), 32'd7);
        chk("ch1_hi", 32'(hi_len[1]), 32'd3);
        chk("ch1_lo", 32'(lo_len[1]), 32'd4);
        chk("ch0_unchanged", 32'(period[0]), 32'd100);
        #1 chk("ch1_ready_after", 32'(cfg_ready), 32'd1);

        // D=1 then D=2 to stopped ch2
        en = 5'b11011;
        repeat (3) step();
        cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 32'd1;
        step();
        cfg_valid = 1'b0;
        en = '1;
        clr_counts();
        repeat (10) step();
        chk("d1_ticks", 32'(tick_cnt[2]), 32'd10);
        chk("d1_wave", 32'(hi_cnt[2]), 32'd0);
        en = 5'b11011;
        repeat (2) step();
        cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 32'd2;
        step();
        cfg_valid = 1'b0;
        en = '1;
        clr_counts();
        repeat (10) step();
        chk("d2_ticks", 32'(tick_cnt[2]), 32'd5);
        chk("d2_wave", 32'(hi_cnt[2]), 32'd5);
        chk("d2_period", 32'(period[2]), 32'd2);
        chk("d2_hi", 32'(hi_len[2]), 32'd1);
        chk("d2_lo", 32'(lo_len[2]), 32'd1);

        // restart with channels at different phases
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("restart_tick", 32'(tick), 32'd0);
        chk("restart_wave", 32'(wave), 32'd0);
        repeat (7) step();
        chk("restart_r7", 32'(tick), 32'b00010);
        repeat (93) step();
        chk("restart_r100", 32'(tick), 32'b11101);

        // Write on ch0's boundary cycle goes pending for one period
        for (int k = 0; k < 200 && !(m_cnt[0] == m_div[0] - 1); k++) step();
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 32'd13;
        step();
        cfg_valid = 1'b0;
        repeat (100) step();
        chk("bnd_old_period", 32'(tick[0]), 32'd1);
        repeat (13) step();
        chk("bnd_new_tick", 32'(tick[0]), 32'd1);
        chk("bnd_new_period", 32'(period[0]), 32'd13);

        // Write together with restart is immediate
        cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_div = 32'd5; restart = 1'b1;
        step();
        cfg_valid = 1'b0; restart = 1'b0;
        repeat (5) step();
        chk("rs_wr_tick", 32'(tick[3]), 32'd1);
        repeat (20) step();
        chk("rs_wr_period", 32'(period[3]), 32'd5);
        chk("rs_wr_hi", 32'(hi_len[3]), 32'd2);
        chk("rs_wr_lo", 32'(lo_len[3]), 32'd3);

        // Out-of-range channel is accepted and dropped
        cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_div = 32'd3;
        #1 chk("oor_ready", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
        repeat (20) step();
        chk("oor_ch3", 32'(period[3]), 32'd5);
        chk("oor_ch1", 32'(period[1]), 32'd7);

        // Disabling applies a pending divisor
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 32'd3;
        step();
        cfg_valid = 1'b0;
        en = 5'b11110;
        step();
        en = '1;
        repeat (10) step();
        chk("dis_pend_period", 32'(period[0]), 32'd3);

        // D=0 stops a running channel at its next boundary
        cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 32'd0;
        step();
        cfg_valid = 1'b0;
        repeat (3) step();
        clr_counts();
        repeat (6) step();
        chk("d0_ticks", 32'(tick_cnt[2]), 32'd0);
        chk("d0_wave", 32'(hi_cnt[2]), 32'd0);

        // rst mid-period and mid-pending
        cfg_valid = 1'b1; cfg_ch = 3'd4; cfg_div = 32'd9;
        step();
        cfg_valid = 1'b0;
        #1 chk("pre_rst_pend", 32'(cfg_ready), 32'd0);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_tick", 32'(tick), 32'd0);
        chk("mid_rst_wave", 32'(wave), 32'd0);
        #1 chk("mid_rst_ready", 32'(cfg_ready), 32'd1);
        repeat (9) step();
        chk("mid_rst_no_d9", 32'(tick), 32'd0);
        repeat (91) step();
        chk("mid_rst_def", 32'(tick), 32'h1F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
